// File: rtl/hams_pkg.sv
// Shared HAMS datapath types: register-slice state encoding and slice-chain sizing helper.
package hams_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_slice_state_e;

    // Occupancy counter width for a chain of `depth` slices (kept >= 1 for the bypass build).
    function automatic int occ_width(input int depth);
        return (depth == 0) ? 1 : $clog2(2 * depth + 1);
    endfunction

endpackage

// File: rtl/hams_pipe_slice.sv
// One valid/ready register slice: two-entry skid slice with a registered ready,
// or a single-entry slice whose ready ripples combinationally from downstream.
module hams_pipe_slice
    import hams_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter bit SKID_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_vld_i,
    output logic              in_rdy_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_vld_o,
    input  logic              out_rdy_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occ_o
);

    if (SKID_EN) begin : g_skid
        pipe_slice_state_e state_q, state_d;
        logic [DATA_W-1:0] main_q, main_d, skid_q, skid_d;
        logic              in_fire, out_fire;

        assign in_fire  = in_vld_i & (state_q != TWO);
        assign out_fire = (state_q != EMPTY) & out_rdy_i;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) state_q <= EMPTY;
            else        state_q <= state_d;
        end

        // Payload regs carry no reset; validity lives entirely in state_q.
        always_ff @(posedge clk) begin
            main_q <= main_d;
            skid_q <= skid_d;
        end

        always_comb begin
            state_d = state_q;
            main_d  = main_q;
            skid_d  = skid_q;
            case (state_q)
                EMPTY: if (in_fire) begin
                    state_d = ONE;
                    main_d  = in_data_i;
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data_i;
                    end else if (in_fire) begin
                        state_d = TWO;
                        skid_d  = in_data_i;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                TWO: if (out_fire) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
                default: state_d = EMPTY;
            endcase
            if (flush_i) state_d = EMPTY;
        end

        always_comb begin
            in_rdy_o   = (state_q != TWO);
            out_vld_o  = (state_q != EMPTY);
            out_data_o = main_q;
            occ_o      = {state_q == TWO, state_q == ONE};
        end
    end else begin : g_plain
        logic              vld_q, vld_d;
        logic [DATA_W-1:0] data_q, data_d;
        logic              rdy;

        assign rdy = ~vld_q | out_rdy_i;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) vld_q <= 1'b0;
            else        vld_q <= vld_d;
        end

        always_ff @(posedge clk) data_q <= data_d;

        always_comb begin
            vld_d  = rdy ? in_vld_i : vld_q;
            data_d = (rdy & in_vld_i) ? in_data_i : data_q;
            if (flush_i) vld_d = 1'b0;
        end

        always_comb begin
            in_rdy_o   = rdy;
            out_vld_o  = vld_q;
            out_data_o = data_q;
            occ_o      = {1'b0, vld_q};
        end
    end

endmodule

// File: rtl/hams_pipe_rs.sv
// Valid/ready register-slice chain of DEPTH slices with flush and occupancy count;
// DEPTH=0 degenerates to a wire-through.
module hams_pipe_rs
    import hams_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int DEPTH   = 2,
    parameter  bit SKID_EN = 1'b1,
    localparam int OCC_W   = occ_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              vld_i,
    output logic              rdy_o,
    input  logic [DATA_W-1:0] data_i,
    output logic              vld_o,
    input  logic              rdy_i,
    output logic [DATA_W-1:0] data_o,
    output logic [OCC_W-1:0]  occ_o
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_ok;
        assign unused_ok = ^{clk, rst_n, flush_i};
        assign vld_o  = vld_i;
        assign rdy_o  = rdy_i;
        assign data_o = data_i;
        assign occ_o  = '0;
    end else begin : g_chain
        // Index k is the input side of slice k; index DEPTH is the chain output.
        logic [DEPTH:0]             vld, rdy;
        logic [DEPTH:0][DATA_W-1:0] data;
        logic [DEPTH-1:0][1:0]      occ;
        logic [OCC_W-1:0]           occ_sum;

        assign vld[0]     = vld_i;
        assign data[0]    = data_i;
        assign rdy[DEPTH] = rdy_i;
        assign rdy_o      = rdy[0];
        assign vld_o      = vld[DEPTH];
        assign data_o     = data[DEPTH];

        for (genvar k = 0; k < DEPTH; k++) begin : g_slice
            hams_pipe_slice #(
                .DATA_W (DATA_W),
                .SKID_EN(SKID_EN)
            ) u_slice (
                .clk       (clk),
                .rst_n     (rst_n),
                .flush_i   (flush_i),
                .in_vld_i  (vld[k]),
                .in_rdy_o  (rdy[k]),
                .in_data_i (data[k]),
                .out_vld_o (vld[k+1]),
                .out_rdy_i (rdy[k+1]),
                .out_data_o(data[k+1]),
                .occ_o     (occ[k])
            );
        end

        // Sum of flop-derived per-slice counts: reflects the post-edge held entries.
        always_comb begin
            occ_sum = '0;
            for (int k = 0; k < DEPTH; k++) occ_sum = occ_sum + OCC_W'(occ[k]);
        end

        assign occ_o = occ_sum;
    end

endmodule

// File: tb/tb_hams_pipe_rs.sv
// Bench for hams_pipe_rs: eight chain configurations, each checked every cycle against
// a queue model of held entries, plus directed stream/stall/flush/reset/ready vectors.
module tb_hams_pipe_rs;

    localparam int NC = 8;
    localparam int DEP [NC] = '{2, 2, 0, 0, 1, 1, 3, 3};
    localparam bit SKD [NC] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vi [NC];
    logic        ri [NC];
    logic        fl [NC];
    logic        vo [NC];
    logic        ro [NC];
    logic [31:0] di [NC];
    logic [31:0] dout [NC];
    logic [3:0]  oc [NC];
    int          dlv [NC];
    int          errs = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s inst%0d: got %0h expected %0h", nm, g, act, exp);
        end
    endtask

    for (genvar g = 0; g < NC; g++) begin : g_cfg
        localparam int D  = DEP[g];
        localparam bit S  = SKD[g];
        localparam int OW = (D == 0) ? 1 : $clog2(2 * D + 1);

        logic [OW-1:0] occ_l;
        logic [31:0]   q[$];
        logic          hold;
        logic [31:0]   hdat;

        hams_pipe_rs #(.DATA_W(32), .DEPTH(D), .SKID_EN(S)) dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .flush_i(fl[g]),
            .vld_i  (vi[g]),
            .rdy_o  (ro[g]),
            .data_i (di[g]),
            .vld_o  (vo[g]),
            .rdy_i  (ri[g]),
            .data_o (dout[g]),
            .occ_o  (occ_l)
        );
        assign oc[g] = 4'(occ_l);

        // Model: q holds exactly the accepted-but-undelivered payloads, oldest first.
        initial begin
            hold = 1'b0;
            hdat = '0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    q.delete();
                    hold = 1'b0;
                end else if (D == 0) begin
                    chk("byp_vld", g, 32'(vo[g]), 32'(vi[g]));
                    chk("byp_rdy", g, 32'(ro[g]), 32'(ri[g]));
                    chk("byp_data", g, dout[g], di[g]);
                    chk("byp_occ", g, 32'(oc[g]), 32'd0);
                    if (vi[g] && ri[g]) dlv[g]++;
                end else begin
                    chk("occ", g, 32'(oc[g]), 32'(q.size()));
                    chk("vld_src", g, 32'(vo[g] && q.size() == 0), 32'd0);
                    if (vo[g] && q.size() > 0) chk("data", g, dout[g], q[0]);
                    if (hold) begin
                        chk("hold_vld", g, 32'(vo[g]), 32'd1);
                        chk("hold_data", g, dout[g], hdat);
                    end
                    if (S) begin
                        if (q.size() == 0)     chk("rdy_empty", g, 32'(ro[g]), 32'd1);
                        if (q.size() == 2 * D) chk("rdy_full", g, 32'(ro[g]), 32'd0);
                    end else begin
                        chk("rdy_comb", g, 32'(ro[g]), 32'(q.size() < D || ri[g]));
                    end
                    hold = vo[g] && !ri[g] && !fl[g];
                    hdat = dout[g];
                    if (vo[g] && ri[g]) begin
                        if (q.size() > 0) void'(q.pop_front());
                        dlv[g]++;
                    end
                    if (fl[g]) q.delete();
                    else if (vi[g] && ro[g]) q.push_back(di[g]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        bit done;
        for (int i = 0; i < NC; i++) begin
            vi[i] = 1'b0; ri[i] = 1'b1; fl[i] = 1'b0; di[i] = '0; dlv[i] = 0;
        end
        step(); step();
        chk("rst_vld", 0, 32'(vo[0]), 32'd0);
        chk("rst_occ", 0, 32'(oc[0]), 32'd0);
        chk("rst_rdy", 0, 32'(ro[0]), 32'd1);
        chk("rst_rdy", 1, 32'(ro[1]), 32'd1);
        rst_n = 1'b1;
        step();

        // Stream 1..16 back-to-back: data_o trails acceptance by 2 cycles.
        for (int k = 0; k < 20; k++) begin
            vi[0] = (k < 16);
            di[0] = 32'(k + 1);
            @(negedge clk);
            if (k >= 2 && k < 18) begin
                chk("stream_vld", 0, 32'(vo[0]), 32'd1);
                chk("stream_data", 0, dout[0], 32'(k - 1));
            end else begin
                chk("stream_idle", 0, 32'(vo[0]), 32'd0);
            end
            if (k >= 2 && k <= 16) chk("stream_occ", 0, 32'(oc[0]), 32'd2);
            step();
        end

        // Stall: rdy_i low, vld_i high -> exactly 4 accepted.
        ri[0] = 1'b0;
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            vi[0] = 1'b1;
            di[0] = 32'h100 + 32'(k);
            @(negedge clk);
            if (vi[0] && ro[0]) acc++;
            step();
        end
        vi[0] = 1'b0;
        chk("stall_acc", 0, 32'(acc), 32'd4);
        @(negedge clk);
        chk("stall_rdy", 0, 32'(ro[0]), 32'd0);
        chk("stall_occ", 0, 32'(oc[0]), 32'd4);
        step();
        ri[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("drain_vld", 0, 32'(vo[0]), 32'd1);
            chk("drain_data", 0, dout[0], 32'h100 + 32'(k));
            step();
        end
        @(negedge clk);
        chk("drain_done", 0, 32'(vo[0]), 32'd0);
        step();

        // Flush with a concurrent upstream offer of 0xAA.
        ri[0] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            vi[0] = 1'b1;
            di[0] = 32'h200 + 32'(k);
            step();
        end
        di[0] = 32'hAA;
        fl[0] = 1'b1;
        @(negedge clk);
        chk("pre_flush_occ", 0, 32'(oc[0]), 32'd4);
        step();
        fl[0] = 1'b0;
        vi[0] = 1'b0;
        @(negedge clk);
        chk("flush_occ", 0, 32'(oc[0]), 32'd0);
        chk("flush_vld", 0, 32'(vo[0]), 32'd0);
        step();
        ri[0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("flush_quiet", 0, 32'(vo[0]), 32'd0);
            step();
        end

        // Asynchronous reset with three entries in flight.
        ri[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            vi[0] = 1'b1;
            di[0] = 32'h300 + 32'(k);
            step();
        end
        vi[0] = 1'b0;
        @(negedge clk);
        chk("pre_rst_occ", 0, 32'(oc[0]), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_vld", 0, 32'(vo[0]), 32'd0);
        chk("arst_occ", 0, 32'(oc[0]), 32'd0);
        chk("arst_rdy", 0, 32'(ro[0]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        step();
        rst_n = 1'b1;
        ri[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            vi[0] = 1'b1;
            di[0] = 32'h400 + 32'(k);
            step();
        end
        vi[0] = 1'b0;
        repeat (2) step();
        @(negedge clk);
        chk("post_rst_data", 0, dout[0], 32'h402);
        step();

        // SKID_EN=0: capacity 2, rdy_o tracks rdy_i when full.
        ri[1] = 1'b0;
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            vi[1] = 1'b1;
            di[1] = 32'h500 + 32'(k);
            @(negedge clk);
            if (vi[1] && ro[1]) acc++;
            step();
        end
        chk("plain_cap", 1, 32'(acc), 32'd2);
        for (int k = 0; k < 4; k++) begin
            ri[1] = k[0];
            di[1] = 32'h600 + 32'(k);
            @(negedge clk);
            chk("plain_rdy", 1, 32'(ro[1]), 32'(k[0]));
            chk("plain_occ", 1, 32'(oc[1]), 32'd2);
            step();
        end
        vi[1] = 1'b0;
        ri[1] = 1'b1;
        repeat (4) step();

        // Random traffic on DEPTH 0/1/3 in both modes.
        done = 1'b0;
        for (int c = 0; c < 20000 && !done; c++) begin
            for (int g = 2; g < NC; g++) begin
                vi[g] = 1'($urandom_range(0, 1));
                ri[g] = 1'($urandom_range(0, 1));
                di[g] = $urandom;
            end
            step();
            done = 1'b1;
            for (int g = 2; g < NC; g++) if (dlv[g] < 1000) done = 1'b0;
        end
        chk("rand_budget", 2, 32'(done), 32'd1);
        for (int g = 2; g < NC; g++) begin
            vi[g] = 1'b0;
            ri[g] = 1'b1;
        end
        repeat (10) step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
